// File: rtl/t_flip_flop_counter.sv
// Three-stage synchronous T flip-flop counter; {Q3,Q2,Q1} advances by one per rising clk edge and wraps modulo 8.
// Latency: registered outputs that change on the counting edge. Free-running, with no backpressure.

// Toggle cell. Reset clears q at once. A clk edge toggles q when t is high.
// Latency: one edge. No backpressure.
module t_ff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// Binary up-counter built from three toggle cells that share clk (no ripple clocking).
// Latency: the count changes on the same rising edge. Free-running, with no backpressure.
module t_flip_flop_counter (
    input  logic clk,
    input  logic RSTN,
    output logic Q1,
    output logic Q2,
    output logic Q3
);

    logic t1;
    logic t2;
    logic t3;

    // A stage toggles only when every lower stage is at 1, which is the carry of +1.
    assign t1 = 1'b1;
    assign t2 = Q1;
    assign t3 = Q1 & Q2;

    t_ff_cell u_stage1 (
        .clk   (clk),
        .rst_n (RSTN),
        .t     (t1),
        .q     (Q1)
    );

    t_ff_cell u_stage2 (
        .clk   (clk),
        .rst_n (RSTN),
        .t     (t2),
        .q     (Q2)
    );

    t_ff_cell u_stage3 (
        .clk   (clk),
        .rst_n (RSTN),
        .t     (t3),
        .q     (Q3)
    );

endmodule

// File: tb/tb_t_flip_flop_counter.sv
// Scoreboard bench for t_flip_flop_counter. The stimulus side queues the count that is expected in each half clock period.
// A separate monitor samples the outputs 2 ns after every clk transition and compares them with the queue.
module tb_t_flip_flop_counter;

    logic clk = 1'b0;
    logic RSTN = 1'b0;
    logic Q1;
    logic Q2;
    logic Q3;

    logic [2:0] exp_q[$];
    time        rise_t[$];
    time        fall_t[$];
    logic       meas_en = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    // Hand-computed count after edge n (n = 1, 2, ...) following reset release.
    logic [2:0] seq [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

    t_flip_flop_counter dut (
        .clk  (clk),
        .RSTN (RSTN),
        .Q1   (Q1),
        .Q2   (Q2),
        .Q3   (Q3)
    );

    always #10 clk = ~clk;

    always @(posedge Q3) if (meas_en) rise_t.push_back($time);
    always @(negedge Q3) if (meas_en) fall_t.push_back($time);

    task automatic half(input logic [2:0] e);
        @(clk);
        exp_q.push_back(e);
    endtask

    task automatic check_time(input string name, input time got, input time want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0t required %0t", name, got, want);
        end
    endtask

    // Monitor
    initial begin
        logic [2:0] e;
        #5;
        forever begin
            @(clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({Q3, Q2, Q1} !== e) begin
                    n_err++;
                    $display("FAIL count @%0t: got %b required %b", $time, {Q3, Q2, Q1}, e);
                end
            end
        end
    end

    // Stimulus
    initial begin
        #5;
        // Reset held low: edges at 10..90 ns must be ignored.
        for (int i = 0; i < 10; i++) half(3'd0);
        RSTN = 1'b1;                     // t = 100 ns, at the falling edge of clk
        meas_en = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            half(seq[(k - 1) % 8]);
            half(seq[(k - 1) % 8]);
        end
        meas_en = 1'b0;
        // Three more edges bring the count to 5 at 1150 ns.
        for (int k = 51; k <= 53; k++) begin
            half(seq[(k - 1) % 8]);
            if (k != 53) half(seq[(k - 1) % 8]);
        end
        #5 RSTN = 1'b0;                  // 1155 ns, mid-period, with the count at 5
        for (int i = 0; i < 5; i++) half(3'd0);
        #5 RSTN = 1'b1;                  // 1205 ns, away from any edge
        for (int k = 1; k <= 8; k++) begin
            half(seq[k - 1]);
            half(seq[k - 1]);
        end
        #20;

        // Q3 must have a 160 ns period with 80 ns high and 80 ns low, measured after its first cycle.
        if (rise_t.size() >= 3 && fall_t.size() >= 2) begin
            check_time("q3_period", rise_t[2] - rise_t[1], 160);
            check_time("q3_high", fall_t[1] - rise_t[1], 80);
            check_time("q3_low", rise_t[2] - fall_t[1], 80);
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL q3_edges: got %0d rises required at least 3", rise_t.size());
        end

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
